octal_entry_ctrl: RTL and testbench

Keypad-driven operand entry and result capture controller placed directly upstream of `octal_sub`. It assembles two 2-digit octal operands from a key stream and drives `a`, `b` and `cin` into the subtractor. It then waits a fixed settle time and captures the subtractor's `d` output into a held result register with a valid flag.

---
 rtl/octal_pkg.sv | 23 ++
 rtl/octal_key_decode.sv | 29 ++
 rtl/octal_entry_ctrl.sv | 156 +++++++++++++++
 tb/tb_octal_entry_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/octal_pkg.sv
`default_nettype none
// ============================================================================
// Module   : octal_pkg
// Brief    : Shared key codes, digit width and entry FSM states.
// Revision : 1.0
// ============================================================================
package octal_pkg;

  localparam int OCT_DIGIT_W = 3;

  localparam logic [3:0] KEY_ENTER  = 4'd10;
  localparam logic [3:0] KEY_CLEAR  = 4'd11;
  localparam logic [3:0] KEY_BORROW = 4'd12;

  typedef enum logic [1:0] {
    ST_ENT_A  = 2'd0,
    ST_ENT_B  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DONE   = 2'd3
  } entry_state_t;

endpackage
`default_nettype wire

// File: rtl/octal_key_decode.sv
`default_nettype none
// ============================================================================
// Module   : octal_key_decode
// Brief    : Classifies a qualified key code into digit/command strobes.
// Revision : 1.0
// ============================================================================
module octal_key_decode
  import octal_pkg::*;
(
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic       is_digit,
  output logic       is_bad_digit,
  output logic       is_enter,
  output logic       is_clear,
  output logic       is_borrow
);

  // Codes 13-15 match nothing and fall through silently.
  always_comb begin
    is_digit     = key_valid && (key_code[3] == 1'b0);
    is_bad_digit = key_valid && ((key_code == 4'd8) || (key_code == 4'd9));
    is_enter     = key_valid && (key_code == KEY_ENTER);
    is_clear     = key_valid && (key_code == KEY_CLEAR);
    is_borrow    = key_valid && (key_code == KEY_BORROW);
  end

endmodule
`default_nettype wire

// File: rtl/octal_entry_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : octal_entry_ctrl
// Brief    : Keypad operand entry for octal_sub with timed result capture.
// Revision : 1.0
// ============================================================================
module octal_entry_ctrl
  import octal_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic [5:0] a,
  output logic [5:0] b,
  output logic       cin,
  input  logic [5:0] d,
  output logic [5:0] result,
  output logic       result_valid,
  output logic       busy,
  output logic       err
);

  localparam logic [3:0] c_settle_load = 4'(SETTLE_CYCLES - 1);

  entry_state_t r_state, w_state;
  logic [5:0]   r_a, w_a;
  logic [5:0]   r_b, w_b;
  logic         r_cin, w_cin;
  logic [1:0]   r_cnt, w_cnt;
  logic [3:0]   r_scnt, w_scnt;
  logic [5:0]   r_result, w_result;
  logic         r_rv, w_rv;
  logic         r_err, w_err;

  logic w_is_digit, w_is_bad, w_is_enter, w_is_clear, w_is_borrow;
  logic [OCT_DIGIT_W-1:0] w_digit;

  octal_key_decode u_decode (
    .key_code     (key_code),
    .key_valid    (key_valid),
    .is_digit     (w_is_digit),
    .is_bad_digit (w_is_bad),
    .is_enter     (w_is_enter),
    .is_clear     (w_is_clear),
    .is_borrow    (w_is_borrow)
  );

  assign w_digit = key_code[OCT_DIGIT_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_ENT_A;
      r_a      <= '0;
      r_b      <= '0;
      r_cin    <= 1'b0;
      r_cnt    <= '0;
      r_scnt   <= '0;
      r_result <= '0;
      r_rv     <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_a      <= w_a;
      r_b      <= w_b;
      r_cin    <= w_cin;
      r_cnt    <= w_cnt;
      r_scnt   <= w_scnt;
      r_result <= w_result;
      r_rv     <= w_rv;
      r_err    <= w_err;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_a      = r_a;
    w_b      = r_b;
    w_cin    = r_cin;
    w_cnt    = r_cnt;
    w_scnt   = r_scnt;
    w_result = r_result;
    w_rv     = r_rv;
    w_err    = 1'b0;

    // CLEAR overrides everything, including a capture on the same edge.
    if (w_is_clear) begin
      w_state = ST_ENT_A;
      w_a     = '0;
      w_b     = '0;
      w_cin   = 1'b0;
      w_cnt   = '0;
      w_rv    = 1'b0;
    end else begin
      case (r_state)
        ST_ENT_A, ST_ENT_B: begin
          if (w_is_digit) begin
            if (r_cnt == 2'd2) begin
              w_err = 1'b1;
            end else begin
              if (r_state == ST_ENT_A) w_a = {r_a[OCT_DIGIT_W-1:0], w_digit};
              else                     w_b = {r_b[OCT_DIGIT_W-1:0], w_digit};
              w_cnt = r_cnt + 2'd1;
            end
          end else if (w_is_bad) begin
            w_err = 1'b1;
          end else if (w_is_enter) begin
            if (r_state == ST_ENT_A) begin
              w_state = ST_ENT_B;
              w_cnt   = '0;
            end else begin
              w_state = ST_SETTLE;
              w_scnt  = c_settle_load;
            end
          end else if (w_is_borrow) begin
            w_cin = ~r_cin;
          end
        end
        ST_SETTLE: begin
          if (r_scnt == 4'd0) begin
            w_result = d;
            w_rv     = 1'b1;
            w_state  = ST_DONE;
          end else begin
            w_scnt = r_scnt - 4'd1;
          end
        end
        ST_DONE: begin
          if (w_is_digit) begin
            w_a     = {{OCT_DIGIT_W{1'b0}}, w_digit};
            w_b     = '0;
            w_cin   = 1'b0;
            w_cnt   = 2'd1;
            w_rv    = 1'b0;
            w_state = ST_ENT_A;
          end else if (w_is_bad) begin
            w_err = 1'b1;
          end
        end
        default: w_state = ST_ENT_A;
      endcase
    end
  end

  assign a            = r_a;
  assign b            = r_b;
  assign cin          = r_cin;
  assign result       = r_result;
  assign result_valid = r_rv;
  assign busy         = (r_state == ST_SETTLE);
  assign err          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_octal_entry_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_octal_entry_ctrl
// Brief    : Scoreboard bench: directed key sequences, queued result checks.
// Revision : 1.0
// ============================================================================
module tb_octal_entry_ctrl;

  localparam int S = 2;
  localparam logic [3:0] K_ENT = 4'd10;
  localparam logic [3:0] K_CLR = 4'd11;
  localparam logic [3:0] K_BOR = 4'd12;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic [5:0] a, b, d, result;
  logic       cin, result_valid, busy, err;

  typedef struct {
    logic [5:0] res;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_edge = 0;
  int   err_seen = 0;
  logic rv_prev = 1'b0;

  octal_entry_ctrl #(.SETTLE_CYCLES(S)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_code     (key_code),
    .key_valid    (key_valid),
    .a            (a),
    .b            (b),
    .cin          (cin),
    .d            (d),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy),
    .err          (err)
  );

  // Behavioural stand-in for the downstream subtractor.
  assign d = a - b - {5'b0, cin};

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total = total + 1;
    if (act != exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every result_valid rise.
  always @(negedge clk) begin
    if (err) err_seen = err_seen + 1;
    if (result_valid && !rv_prev) begin
      if (q.size() == 0) begin
        chk("unexpected_capture", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result", int'(result), int'(e.res));
        chk("capture_cycle", cyc, e.cyc);
      end
    end
    rv_prev = result_valid;
  end

  task automatic key(input logic [3:0] k);
    @(negedge clk);
    key_code  = k;
    key_valid = 1'b1;
    last_edge = cyc + 1;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      key_valid = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic enter_push(input logic [5:0] res);
    key(K_ENT);
    q.push_back('{res, last_edge + S});
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && q.size() > 0; i++) idle(1);
    idle(1);
    chk("drain", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    key_code  = 4'd0;
    key_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a", int'(a), 0);
    chk("rst_b", int'(b), 0);
    chk("rst_out", int'({cin, result_valid, busy, err}), 0);
    chk("rst_result", int'(result), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 0o53 - 0o27 = 0o24
    key(4'd5); key(4'd3);
    chk("a_53", int'(a), 8'o53);
    key(K_ENT); key(4'd2); key(4'd7);
    chk("b_27", int'(b), 8'o27);
    enter_push(6'o24);
    chk("busy_e0", int'(busy), 1);
    idle(1);
    chk("busy_e1", int'(busy), 1);
    idle(1);
    chk("busy_e2", int'(busy), 0);
    drain();

    // Borrow: 1 - 1 - 1 wraps to 0o77; CLEAR keeps old result.
    key(K_CLR);
    chk("clr_result_held", int'(result), 6'o24);
    chk("clr_rv", int'(result_valid), 0);
    key(4'd1); key(K_ENT); key(K_BOR);
    chk("cin_set", int'(cin), 1);
    key(4'd1);
    enter_push(6'o77);
    drain();

    // A < B: 0o05 - 0o12 = 0o73
    key(K_CLR); key(4'd5); key(K_ENT); key(4'd1); key(4'd2);
    enter_push(6'o73);
    drain();

    // Third digit rejected; bad digits in ENT_B, back to back.
    key(K_CLR); key(4'd4); key(4'd6); key(4'd7);
    chk("err_third", int'(err), 1);
    chk("a_46", int'(a), 8'o46);
    key(K_ENT); key(4'd1); key(4'd9);
    chk("err_bad1", int'(err), 1);
    key(4'd9);
    chk("err_bad2", int'(err), 1);
    chk("b_held", int'(b), 1);
    enter_push(6'o45);
    drain();

    // Zero digits for B; DONE ignores ENTER/BORROW; digit restarts.
    key(K_CLR); key(4'd3); key(K_ENT);
    enter_push(6'o03);
    drain();
    key(K_BOR);
    chk("done_cin", int'(cin), 0);
    key(K_ENT);
    chk("done_rv", int'({result_valid, busy}), 2);
    key(4'd2);
    chk("restart_a", int'(a), 2);
    chk("restart_rv", int'(result_valid), 0);
    key(4'd1);
    chk("restart_a21", int'(a), 8'o21);
    key(4'd4);
    chk("restart_err", int'(err), 1);
    key(K_ENT); enter_push(6'o21);
    drain();

    // CLEAR on the capture edge wins.
    key(K_CLR); key(4'd3); key(K_ENT); key(4'd1); key(K_ENT);
    idle(1);
    key(K_CLR);
    chk("clrcap_rv", int'(result_valid), 0);
    chk("clrcap_result", int'(result), 6'o21);
    chk("clrcap_a", int'(a), 0);
    idle(5);

    // Keys during SETTLE are ignored and timing holds.
    key(4'd6); key(K_ENT); key(4'd2);
    enter_push(6'o04);
    key(4'd5);
    key(4'd8);
    chk("settle_noerr", int'(err), 0);
    chk("settle_ab", int'({a, b}), int'({6'o06, 6'o02}));
    drain();

    // Asynchronous reset mid-SETTLE aborts without capture.
    key(K_CLR); key(4'd1); key(K_ENT); key(K_ENT);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ab", int'({a, b}), 0);
    chk("arst_out", int'({cin, result_valid, busy, err}), 0);
    chk("arst_result", int'(result), 0);
    @(negedge clk);
    rst_n = 1'b1;
    key(4'd4);
    chk("arst_enta", int'(a), 4);
    idle(6);

    chk("err_total", err_seen, 4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
